// File: rtl/descaler.sv
// descaler - fixed-point inverse scaler.
//
// Divides a signed sample by the real constant SCALE and returns sig_i / SCALE
// as a signed integer sample. The divisor is held as the unsigned fixed-point
// constant D = floor(SCALE * 2^FRAC). The quotient is produced by a sequential
// radix-2 restoring divider working on the magnitude, so no multipliers/DSPs
// are used. The sign is re-applied at the end, so rounding is symmetric about
// zero, and the result saturates symmetrically to +/-(2^(OWIDTH-1)-1).
//
// Optional feature macro: DESCALER_ROUND_EN
//   defined   : round half away from zero (2*remainder >= D bumps the magnitude)
//   undefined : truncate toward zero (no rounding adder is built)
//
// Ports:
//   clk_i     in   clock
//   rst_i     in   asynchronous active-high reset
//   clk_en_i  in   clock enable; all registers hold while low
//   sig_i     in   signed dividend sample (IWIDTH)
//   valid_i   in   sig_i is valid
//   ready_o   out  block can accept a sample (IDLE only)
//   sig_o     out  signed quotient (OWIDTH)
//   valid_o   out  sig_o is valid (DONE only)
//   ready_i   in   downstream accepts sig_o
//   sig_fault out  quotient was saturated, qualified by valid_o
module descaler #(
  parameter int  IWIDTH = 16,
  parameter int  OWIDTH = 16,
  parameter real SCALE  = 1.046566592,
  parameter int  FRAC   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clk_en_i,
  input  logic [IWIDTH-1:0] sig_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [OWIDTH-1:0] sig_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              sig_fault
);

  // Dividend width: magnitude of the sample with FRAC zero bits appended.
  localparam int N = IWIDTH + FRAC;

  // Divisor D = floor(SCALE * 2^FRAC). A real-to-integer cast rounds, so step
  // back by one when the cast landed above the exact product.
  localparam real    D_REAL = SCALE * (2.0 ** FRAC);
  localparam longint D_RND  = longint'(D_REAL);
  localparam longint D_VAL  = (real'(D_RND) > D_REAL) ? (D_RND - 64'sd1) : D_RND;

  localparam int DW = (D_VAL < 64'sd1) ? 1 : $clog2(D_VAL + 64'sd1);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [DW:0]   D_REM   = (DW+1)'(D_VAL);
  localparam logic [N:0]    MAX_MAG = (N+1)'((64'sd1 <<< (OWIDTH - 1)) - 64'sd1);
  localparam logic [CW-1:0] CNT_TOP = CW'(N - 1);

  if (D_VAL <= 64'sd0) begin : g_bad_scale
    $error("descaler: SCALE * 2^FRAC floors to a zero divisor");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [DW:0]       rem_q;
  logic [N-1:0]      quo_q;     // dividend bits shift out of the top, quotient bits shift in at the bottom
  logic              neg_q;
  logic              ready_q;
  logic              valid_q;
  logic [OWIDTH-1:0] sig_q;
  logic              fault_q;

  logic [IWIDTH-1:0] mag_in_s;
  logic [N-1:0]      dividend_s;
  logic [DW+1:0]     rem_shift_s;
  logic              ge_s;
  logic [DW:0]       rem_d;
  logic [N-1:0]      quo_d;
  logic [N:0]        mag_s;
  logic              sat_s;
  logic [OWIDTH-1:0] mag_out_s;
  logic [OWIDTH-1:0] sig_d;

  // Magnitude of the incoming sample; -2^(IWIDTH-1) maps to 2^(IWIDTH-1) unsigned.
  always_comb begin
    mag_in_s   = '0;
    dividend_s = '0;
    if (sig_i[IWIDTH-1]) begin
      mag_in_s = IWIDTH'(0) - sig_i;
    end else begin
      mag_in_s = sig_i;
    end
    dividend_s = {mag_in_s, {FRAC{1'b0}}};
  end

  // One restoring-division step: shift in the next dividend bit, subtract D if it fits.
  always_comb begin
    rem_shift_s = {rem_q, quo_q[N-1]};
    ge_s        = (rem_shift_s >= {1'b0, D_REM});
    if (ge_s) begin
      rem_d = (DW+1)'(rem_shift_s - {1'b0, D_REM});
    end else begin
      rem_d = (DW+1)'(rem_shift_s);
    end
    quo_d = {quo_q[N-2:0], ge_s};
  end

  // Final magnitude (optionally rounded), saturation and sign re-application.
  always_comb begin
    mag_s     = '0;
    sat_s     = 1'b0;
    mag_out_s = '0;
    sig_d     = '0;
`ifdef DESCALER_ROUND_EN
    // Round half away from zero: the dropped fraction is rem/D, so compare 2*rem with D.
    if ({rem_q, 1'b0} >= {1'b0, D_REM}) begin
      mag_s = {1'b0, quo_q} + (N+1)'(1);
    end else begin
      mag_s = {1'b0, quo_q};
    end
`else
    mag_s = {1'b0, quo_q};
`endif
    sat_s = (mag_s > MAX_MAG);
    if (sat_s) begin
      mag_out_s = OWIDTH'(MAX_MAG);
    end else begin
      mag_out_s = OWIDTH'(mag_s);
    end
    if (neg_q) begin
      sig_d = OWIDTH'(0) - mag_out_s;
    end else begin
      sig_d = mag_out_s;
    end
  end

  // Control FSM and datapath registers; everything freezes while clk_en_i is low.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      neg_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      sig_q   <= '0;
      fault_q <= 1'b0;
    end else if (clk_en_i) begin
      case (state_q)
        S_IDLE: begin
          if (valid_i && ready_q) begin
            neg_q   <= sig_i[IWIDTH-1];
            quo_q   <= dividend_s;
            rem_q   <= '0;
            cnt_q   <= CNT_TOP;
            ready_q <= 1'b0;
            state_q <= S_DIV;
          end
        end
        S_DIV: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          if (cnt_q == '0) begin
            state_q <= S_FIX;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_FIX: begin
          sig_q   <= sig_d;
          fault_q <= sat_s;
          valid_q <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          if (ready_i) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ready_o   = ready_q;
  assign valid_o   = valid_q;
  assign sig_o     = sig_q;
  assign sig_fault = fault_q;

endmodule

// File: tb/tb_descaler.sv
// Directed self-checking bench for descaler. Two instances share clock,
// reset and clock enable: dut_a uses the default SCALE (D = 68587),
// dut_b uses SCALE = 0.5 (D = 32768) to reach the saturation bounds.
module tb_descaler;

`ifdef DESCALER_ROUND_EN
  localparam int E1000 = 956;
`else
  localparam int E1000 = 955;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        clk_en_i;

  logic [15:0] sig_a_i, sig_a_o;
  logic        valid_a_i, ready_a_o, valid_a_o, ready_a_i, fault_a_o;
  logic [15:0] sig_b_i, sig_b_o;
  logic        valid_b_i, ready_b_o, valid_b_o, ready_b_i, fault_b_o;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;

  always #5 clk_i = ~clk_i;

  descaler u_dut_a (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clk_en_i (clk_en_i),
    .sig_i    (sig_a_i),
    .valid_i  (valid_a_i),
    .ready_o  (ready_a_o),
    .sig_o    (sig_a_o),
    .valid_o  (valid_a_o),
    .ready_i  (ready_a_i),
    .sig_fault(fault_a_o)
  );

  descaler #(.SCALE(0.5)) u_dut_b (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clk_en_i (clk_en_i),
    .sig_i    (sig_b_i),
    .valid_i  (valid_b_i),
    .ready_o  (ready_b_o),
    .sig_o    (sig_b_o),
    .valid_o  (valid_b_o),
    .ready_i  (ready_b_i),
    .sig_fault(fault_b_o)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int out_sig(input bit sel);
    return sel ? int'($signed(sig_b_o)) : int'($signed(sig_a_o));
  endfunction

  // Push one sample into the selected DUT and wait for valid_o.
  // With toggle set, clk_en_i alternates 0/1 over the first 20 edges.
  task automatic run(input bit sel, input int x, input bit toggle, output int edges);
    bit done;
    @(negedge clk_i);
    if (sel) begin sig_b_i = x[15:0]; valid_b_i = 1'b1; end
    else     begin sig_a_i = x[15:0]; valid_a_i = 1'b1; end
    @(posedge clk_i);
    #1;
    valid_a_i = 1'b0;
    valid_b_i = 1'b0;
    edges = 0;
    done  = 1'b0;
    while (!done && edges < 200) begin
      if (toggle && edges < 20) clk_en_i = edges[0];
      else                      clk_en_i = 1'b1;
      @(posedge clk_i);
      edges++;
      #1;
      done = sel ? valid_b_o : valid_a_o;
    end
    clk_en_i = 1'b1;
    if (!done) check("valid_o timeout", 0, 1);
  endtask

  // Hold ready_i low for hold cycles, then complete the output handshake.
  task automatic drain(input bit sel, input int exp, input int hold);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk_i);
      #1;
      check("bp sig_o stable", out_sig(sel), exp);
      check("bp ready_o low", int'(sel ? ready_b_o : ready_a_o), 0);
      check("bp valid_o held", int'(sel ? valid_b_o : valid_a_o), 1);
    end
    if (sel) ready_b_i = 1'b1; else ready_a_i = 1'b1;
    @(posedge clk_i);
    #1;
    ready_a_i = 1'b0;
    ready_b_i = 1'b0;
    check("hs valid_o low", int'(sel ? valid_b_o : valid_a_o), 0);
    check("hs ready_o high", int'(sel ? ready_b_o : ready_a_o), 1);
  endtask

  initial begin
    rst_i     = 1'b1;
    clk_en_i  = 1'b1;
    sig_a_i   = 16'd0;
    sig_b_i   = 16'd0;
    valid_a_i = 1'b0;
    valid_b_i = 1'b0;
    ready_a_i = 1'b0;
    ready_b_i = 1'b0;

    repeat (3) @(posedge clk_i);
    #1;
    check("rst ready_o", int'(ready_a_o), 1);
    check("rst valid_o", int'(valid_a_o), 0);
    check("rst sig_o", int'(sig_a_o), 0);
    check("rst sig_fault", int'(fault_a_o), 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Default scale, positive sample, latency and back-pressure.
    run(1'b0, 1000, 1'b0, lat);
    check("lat 1000", lat, 33);
    check("q 1000", out_sig(1'b0), E1000);
    check("f 1000", int'(fault_a_o), 0);
    drain(1'b0, E1000, 10);

    run(1'b0, -1000, 1'b0, lat);
    check("q -1000", out_sig(1'b0), -E1000);
    check("f -1000", int'(fault_a_o), 0);
    drain(1'b0, -E1000, 0);

    run(1'b0, 0, 1'b0, lat);
    check("q 0", out_sig(1'b0), 0);
    check("f 0", int'(fault_a_o), 0);
    drain(1'b0, 0, 0);

    // SCALE = 0.5: doubling, then saturation at both ends.
    run(1'b1, 100, 1'b0, lat);
    check("lat b 100", lat, 33);
    check("q b 100", out_sig(1'b1), 200);
    check("f b 100", int'(fault_b_o), 0);
    drain(1'b1, 200, 0);

    run(1'b1, 20000, 1'b0, lat);
    check("q b 20000", out_sig(1'b1), 32767);
    check("f b 20000", int'(fault_b_o), 1);
    drain(1'b1, 32767, 2);

    run(1'b1, -32768, 1'b0, lat);
    check("q b -32768", out_sig(1'b1), -32767);
    check("f b -32768", int'(fault_b_o), 1);
    drain(1'b1, -32767, 0);

    // Clock enable toggled: 10 disabled edges stretch latency to 43.
    run(1'b0, 1000, 1'b1, lat);
    check("lat clk_en", lat, 43);
    check("q clk_en", out_sig(1'b0), E1000);
    drain(1'b0, E1000, 0);

    // Reset in the middle of DIV.
    @(negedge clk_i);
    sig_a_i   = 16'd1000;
    valid_a_i = 1'b1;
    @(posedge clk_i);
    #1;
    valid_a_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #1;
    check("div ready_o low", int'(ready_a_o), 0);
    rst_i = 1'b1;
    #1;
    check("mid rst ready_o", int'(ready_a_o), 1);
    check("mid rst valid_o", int'(valid_a_o), 0);
    check("mid rst sig_o", int'(sig_a_o), 0);
    check("mid rst fault", int'(fault_a_o), 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    run(1'b0, 1000, 1'b0, lat);
    check("lat post rst", lat, 33);
    check("q post rst", out_sig(1'b0), E1000);
    drain(1'b0, E1000, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
